// File: rtl/vision_stream_pkg.sv
// Shared stream-word layout, colour type and frame FSM encoding for the colour
// stages of the vision pipeline.
package vision_stream_pkg;

   localparam int SOP_BIT      = 25;
   localparam int EOP_BIT      = 24;
   localparam int RGB_HI       = 23;
   localparam int RGB_LO       = 0;
   localparam int BBOX_COORD_W = 11;

   typedef struct packed {
      logic [7:0] r;
      logic [7:0] g;
      logic [7:0] b;
   } rgb_t;

   typedef enum logic {
      IDLE,
      ACTIVE
   } frame_state_t;

endpackage

// File: rtl/rgb_range_match.sv
// Combinational inclusive colour-range test: match is high when every channel
// of rgb lies within [min_rgb, max_rgb] (unsigned compares).
module rgb_range_match
   import vision_stream_pkg::*;
(
   input  rgb_t rgb,
   input  rgb_t min_rgb,
   input  rgb_t max_rgb,
   output logic match
);

   logic [23:0] val;
   logic [23:0] lo;
   logic [23:0] hi;
   logic [2:0]  ch_ok;

   assign val = rgb;
   assign lo  = min_rgb;
   assign hi  = max_rgb;

   for (genvar gi = 0; gi < 3; gi++) begin : g_chan
      assign ch_ok[gi] = (val[gi*8 +: 8] >= lo[gi*8 +: 8]) &&
                         (val[gi*8 +: 8] <= hi[gi*8 +: 8]);
   end

   assign match = &ch_ok;

endmodule

// File: rtl/stream_bbox_detect.sv
// Pass-through pixel stream stage that finds the per-frame bounding box of
// in-range pixels. Define BBOX_OVERLAY_EN to outline the previous found box.
module stream_bbox_detect
   import vision_stream_pkg::*;
#(
   parameter int          DATA_WIDTH  = 26,
   parameter int          IMAGE_W     = 640,
   parameter int          IMAGE_H     = 480,
   parameter int          COORD_W     = BBOX_COORD_W,
   parameter int          MIN_PIXELS  = 16,
   parameter logic [23:0] OVERLAY_RGB = 24'hFF00FF
)(
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  valid_in,
   input  logic [DATA_WIDTH-1:0] data_in,
   output logic                  ready_out,
   output logic                  valid_out,
   output logic [DATA_WIDTH-1:0] data_out,
   input  logic                  ready_in,
   input  logic [23:0]           thr_min,
   input  logic [23:0]           thr_max,
   output logic                  bbox_valid,
   output logic                  bbox_found,
   output logic [COORD_W-1:0]    bbox_x0,
   output logic [COORD_W-1:0]    bbox_y0,
   output logic [COORD_W-1:0]    bbox_x1,
   output logic [COORD_W-1:0]    bbox_y1,
   output logic [2*COORD_W-1:0]  bbox_count,
   output logic                  frame_err
);

   localparam int CNT_W = 2*COORD_W;
   localparam logic [COORD_W-1:0] X_LAST = COORD_W'(IMAGE_W-1);
   localparam logic [COORD_W-1:0] Y_LAST = COORD_W'(IMAGE_H-1);

   frame_state_t       state;
   logic [COORD_W-1:0] x_reg, y_reg, x0_reg, y0_reg, x1_reg, y1_reg;
   logic [CNT_W-1:0]   cnt_reg;
   rgb_t               thr_min_reg, thr_max_reg;
   logic               sat_flag_reg;

   logic               accept, beat_sop, beat_eop, in_frame, match, sat_hit, found_next;
   rgb_t               pix_rgb, cur_min, cur_max;
   logic [COORD_W-1:0] pix_x, pix_y, x0_next, y0_next, x1_next, y1_next;
   logic [CNT_W-1:0]   cnt_next;
   logic [DATA_WIDTH-1:0] out_word;

   assign ready_out = ~valid_out | ready_in;
   assign accept    = valid_in & ready_out;
   assign beat_sop  = data_in[SOP_BIT];
   assign beat_eop  = data_in[EOP_BIT];
   assign in_frame  = accept & (beat_sop | (state == ACTIVE));
   assign pix_rgb   = data_in[RGB_HI:RGB_LO];

   // The sop beat is compared against the thresholds being latched with it.
   assign cur_min = beat_sop ? rgb_t'(thr_min) : thr_min_reg;
   assign cur_max = beat_sop ? rgb_t'(thr_max) : thr_max_reg;

   rgb_range_match u_match (
      .rgb     (pix_rgb),
      .min_rgb (cur_min),
      .max_rgb (cur_max),
      .match   (match)
   );

   always_comb begin
      pix_x   = '0;
      pix_y   = '0;
      sat_hit = 1'b0;
      if (!beat_sop) begin
         if (x_reg == X_LAST) begin
            if (y_reg == Y_LAST) begin
               pix_y   = y_reg;
               sat_hit = 1'b1;
            end else begin
               pix_y = y_reg + 1'b1;
            end
         end else begin
            pix_x = x_reg + 1'b1;
            pix_y = y_reg;
         end
      end
   end

   // Accumulator values including the current beat, so eop can publish at once.
   always_comb begin
      x0_next  = beat_sop ? '1 : x0_reg;
      y0_next  = beat_sop ? '1 : y0_reg;
      x1_next  = beat_sop ? '0 : x1_reg;
      y1_next  = beat_sop ? '0 : y1_reg;
      cnt_next = beat_sop ? '0 : cnt_reg;
      if (match) begin
         if (pix_x < x0_next) x0_next = pix_x;
         if (pix_y < y0_next) y0_next = pix_y;
         if (pix_x > x1_next) x1_next = pix_x;
         if (pix_y > y1_next) y1_next = pix_y;
         if (cnt_next != '1) cnt_next = cnt_next + 1'b1;
      end
   end

   assign found_next = (cnt_next >= CNT_W'(MIN_PIXELS));

`ifdef BBOX_OVERLAY_EN
   logic               ovl_on_reg, on_perim;
   logic [COORD_W-1:0] ovl_x0_reg, ovl_y0_reg, ovl_x1_reg, ovl_y1_reg;

   assign on_perim = in_frame && ovl_on_reg &&
      (((pix_x == ovl_x0_reg || pix_x == ovl_x1_reg) && pix_y >= ovl_y0_reg && pix_y <= ovl_y1_reg) ||
       ((pix_y == ovl_y0_reg || pix_y == ovl_y1_reg) && pix_x >= ovl_x0_reg && pix_x <= ovl_x1_reg));
   assign out_word = on_perim ? {data_in[DATA_WIDTH-1:RGB_HI+1], OVERLAY_RGB} : data_in;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ovl_on_reg <= 1'b0;
         ovl_x0_reg <= '0;
         ovl_y0_reg <= '0;
         ovl_x1_reg <= '0;
         ovl_y1_reg <= '0;
      end else if (in_frame && beat_eop) begin
         ovl_on_reg <= found_next;
         ovl_x0_reg <= x0_next;
         ovl_y0_reg <= y0_next;
         ovl_x1_reg <= x1_next;
         ovl_y1_reg <= y1_next;
      end
   end
`else
   logic unused_overlay;
   assign unused_overlay = ^OVERLAY_RGB;
   assign out_word = data_in;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state        <= IDLE;
         valid_out    <= 1'b0;
         data_out     <= '0;
         x_reg        <= '0;
         y_reg        <= '0;
         x0_reg       <= '0;
         y0_reg       <= '0;
         x1_reg       <= '0;
         y1_reg       <= '0;
         cnt_reg      <= '0;
         thr_min_reg  <= '0;
         thr_max_reg  <= '0;
         sat_flag_reg <= 1'b0;
         bbox_valid   <= 1'b0;
         bbox_found   <= 1'b0;
         bbox_x0      <= '0;
         bbox_y0      <= '0;
         bbox_x1      <= '0;
         bbox_y1      <= '0;
         bbox_count   <= '0;
         frame_err    <= 1'b0;
      end else begin
         bbox_valid <= 1'b0;
         frame_err  <= 1'b0;
         if (ready_out) begin
            valid_out <= valid_in;
            if (valid_in) data_out <= out_word;
         end
         if (in_frame) begin
            x_reg   <= pix_x;
            y_reg   <= pix_y;
            x0_reg  <= x0_next;
            y0_reg  <= y0_next;
            x1_reg  <= x1_next;
            y1_reg  <= y1_next;
            cnt_reg <= cnt_next;
            if (beat_sop) begin
               thr_min_reg  <= thr_min;
               thr_max_reg  <= thr_max;
               sat_flag_reg <= 1'b0;
               if (state == ACTIVE) frame_err <= 1'b1;
            end else if (sat_hit && !sat_flag_reg) begin
               sat_flag_reg <= 1'b1;
               frame_err    <= 1'b1;
            end
            if (beat_eop) begin
               state      <= IDLE;
               bbox_valid <= 1'b1;
               bbox_found <= found_next;
               bbox_count <= cnt_next;
               bbox_x0    <= found_next ? x0_next : '0;
               bbox_y0    <= found_next ? y0_next : '0;
               bbox_x1    <= found_next ? x1_next : '0;
               bbox_y1    <= found_next ? y1_next : '0;
            end else begin
               state <= ACTIVE;
            end
         end
      end
   end

endmodule

// File: tb/tb_stream_bbox_detect.sv
// Randomized self-checking bench for stream_bbox_detect against a frame-level
// model built from pixel indices and lists of matching coordinates.
module tb_stream_bbox_detect;

   localparam int IW = 8;
   localparam int IH = 4;
   localparam int MINP = 2;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        valid_in = 1'b0;
   logic [25:0] data_in = '0;
   logic        ready_out;
   logic        valid_out;
   logic [25:0] data_out;
   logic        ready_in = 1'b1;
   logic [23:0] thr_min = 24'h800000;
   logic [23:0] thr_max = 24'hFF3030;
   logic        bbox_valid, bbox_found, frame_err;
   logic [10:0] bbox_x0, bbox_y0, bbox_x1, bbox_y1;
   logic [21:0] bbox_count;

   stream_bbox_detect #(
      .IMAGE_W(IW), .IMAGE_H(IH), .MIN_PIXELS(MINP)
   ) dut (
      .clk(clk), .rst_n(rst_n), .valid_in(valid_in), .data_in(data_in),
      .ready_out(ready_out), .valid_out(valid_out), .data_out(data_out),
      .ready_in(ready_in), .thr_min(thr_min), .thr_max(thr_max),
      .bbox_valid(bbox_valid), .bbox_found(bbox_found),
      .bbox_x0(bbox_x0), .bbox_y0(bbox_y0), .bbox_x1(bbox_x1), .bbox_y1(bbox_y1),
      .bbox_count(bbox_count), .frame_err(frame_err)
   );

   always #5 clk = ~clk;

   int tests = 0;
   int fails = 0;
   int rmode = 0;
   bit check_en = 1'b0;

   // model state
   bit          m_in_frame = 1'b0;
   int          m_n = 0;
   bit          m_err_done = 1'b0;
   logic [23:0] m_tmin, m_tmax;
   int          mx[$];
   int          my[$];
   logic [25:0] m_q[$];
   bit          e_bv = 1'b0, e_err = 1'b0, e_found = 1'b0;
   int          e_x0 = 0, e_y0 = 0, e_x1 = 0, e_y1 = 0, e_cnt = 0;
   bit          ov_on = 1'b0;
   int          ov_x0 = 0, ov_y0 = 0, ov_x1 = 0, ov_y1 = 0;

   // observed DUT results for literal pins
   int          nres = 0, nerr = 0;
   int          g_found = 0, g_x0 = 0, g_y0 = 0, g_x1 = 0, g_y1 = 0, g_cnt = 0;

   task automatic chk(input string name, input longint act, input longint exp);
      tests++;
      if (act != exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic bit in_range(input logic [23:0] v, input logic [23:0] lo, input logic [23:0] hi);
      for (int c = 0; c < 3; c++) begin
         int a, l, h;
         a = int'((v >> (8*c)) & 24'hFF);
         l = int'((lo >> (8*c)) & 24'hFF);
         h = int'((hi >> (8*c)) & 24'hFF);
         if (a < l || a > h) return 1'b0;
      end
      return 1'b1;
   endfunction

   task automatic model_accept(input logic [25:0] d);
      logic [25:0] od;
      int px, py;
      od = d;
      if (d[25]) begin
         if (m_in_frame) e_err = 1'b1;
         m_in_frame = 1'b1;
         m_n = 0;
         m_tmin = thr_min;
         m_tmax = thr_max;
         m_err_done = 1'b0;
         mx.delete();
         my.delete();
      end else if (m_in_frame) begin
         m_n++;
      end
      if (m_in_frame) begin
         px = m_n % IW;
         py = m_n / IW;
         if (py > IH-1) begin
            py = IH-1;
            if (!m_err_done) begin
               e_err = 1'b1;
               m_err_done = 1'b1;
            end
         end
         if (in_range(d[23:0], m_tmin, m_tmax)) begin
            mx.push_back(px);
            my.push_back(py);
         end
`ifdef BBOX_OVERLAY_EN
         if (ov_on && ((((px == ov_x0) || (px == ov_x1)) && py >= ov_y0 && py <= ov_y1) ||
                       (((py == ov_y0) || (py == ov_y1)) && px >= ov_x0 && px <= ov_x1)))
            od[23:0] = 24'hFF00FF;
`endif
         if (d[24]) begin
            int bx0, by0, bx1, by1;
            bx0 = 1 << 30; by0 = 1 << 30; bx1 = -1; by1 = -1;
            foreach (mx[k]) begin
               if (mx[k] < bx0) bx0 = mx[k];
               if (mx[k] > bx1) bx1 = mx[k];
               if (my[k] < by0) by0 = my[k];
               if (my[k] > by1) by1 = my[k];
            end
            e_bv    = 1'b1;
            e_cnt   = mx.size();
            e_found = (e_cnt >= MINP);
            e_x0 = e_found ? bx0 : 0;
            e_y0 = e_found ? by0 : 0;
            e_x1 = e_found ? bx1 : 0;
            e_y1 = e_found ? by1 : 0;
            ov_on = e_found;
            ov_x0 = bx0; ov_y0 = by0; ov_x1 = bx1; ov_y1 = by1;
            m_in_frame = 1'b0;
         end
      end
      m_q.push_back(od);
   endtask

   // compare process: outputs reflect the previous posedge; inputs are the next transfer
   always @(negedge clk) begin
      if (rst_n && check_en) begin
         chk("ready_out", ready_out, !valid_out || ready_in);
         chk("valid_out", valid_out, m_q.size() > 0);
         if (valid_out && m_q.size() > 0) chk("data_out", data_out, m_q[0]);
         chk("bbox_valid", bbox_valid, e_bv);
         chk("frame_err", frame_err, e_err);
         chk("bbox_found", bbox_found, e_found);
         chk("bbox_x0", bbox_x0, e_x0);
         chk("bbox_y0", bbox_y0, e_y0);
         chk("bbox_x1", bbox_x1, e_x1);
         chk("bbox_y1", bbox_y1, e_y1);
         chk("bbox_count", bbox_count, e_cnt);
         if (bbox_valid) begin
            nres++;
            g_found = bbox_found; g_x0 = bbox_x0; g_y0 = bbox_y0;
            g_x1 = bbox_x1; g_y1 = bbox_y1; g_cnt = bbox_count;
            $display("[TB] result found=%0d box=(%0d,%0d)-(%0d,%0d) count=%0d",
                     bbox_found, bbox_x0, bbox_y0, bbox_x1, bbox_y1, bbox_count);
         end
         if (frame_err) begin
            nerr++;
            $display("[TB] frame_err strobe at t=%0t", $time);
         end
         if (valid_out && ready_in && m_q.size() > 0) void'(m_q.pop_front());
         e_bv  = 1'b0;
         e_err = 1'b0;
         if (valid_in && ready_out) model_accept(data_in);
      end
   end

   always @(posedge clk) begin
      #1;
      case (rmode)
         0: ready_in = 1'b1;
         1: ready_in = ~ready_in;
         default: ready_in = 1'($urandom_range(0, 1));
      endcase
   end

   task automatic send_beat(input logic s, input logic e, input logic [23:0] rgb, input int gap);
      bit acc;
      if (gap > 0) begin
         valid_in = 1'b0;
         repeat (gap) begin
            @(posedge clk);
            #1;
         end
      end
      valid_in = 1'b1;
      data_in  = {s, e, rgb};
      acc = 1'b0;
      for (int t = 0; t < 200 && !acc; t++) begin
         @(negedge clk);
         acc = ready_out;
         @(posedge clk);
         #1;
      end
      if (!acc) chk("accept_timeout", 0, 1);
      valid_in = 1'b0;
   endtask

   function automatic logic [23:0] rand_pix();
      logic [7:0] r, g, b;
      if ($urandom_range(0, 2) != 0) begin
         r = 8'($urandom_range(8'h70, 8'hFF));
         g = 8'($urandom_range(0, 8'h38));
         b = 8'($urandom_range(0, 8'h38));
         return {r, g, b};
      end
      return 24'($urandom);
   endfunction

   function automatic logic [23:0] frame_pix(input int kind, input int i);
      logic [23:0] edges [4];
      edges[0] = 24'h800000; edges[1] = 24'hFF3030;
      edges[2] = 24'h7F3030; edges[3] = 24'h803130;
      case (kind)
         0: return 24'h101010;
         1: return (i == 10 || i == 13 || i == 27) ? 24'hC01010 : 24'h101010;
         3: return edges[i % 4];
         default: return rand_pix();
      endcase
   endfunction

   task automatic send_frame(input int n, input int kind, input bit with_eop, input int gapmax);
      for (int i = 0; i < n; i++)
         send_beat(i == 0, with_eop && (i == n-1), frame_pix(kind, i),
                   ($urandom_range(0, 3) == 0) ? $urandom_range(0, gapmax) : 0);
   endtask

   task automatic drain();
      repeat (6) @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      @(posedge clk);
      #2;
      rst_n = 1'b0;
      valid_in = 1'b0;
      #1;
      chk("rst_valid_out", valid_out, 0);
      chk("rst_data_out", data_out, 0);
      chk("rst_bbox_valid", bbox_valid, 0);
      chk("rst_bbox_found", bbox_found, 0);
      chk("rst_bbox_x1", bbox_x1, 0);
      chk("rst_bbox_count", bbox_count, 0);
      chk("rst_frame_err", frame_err, 0);
      m_q.delete();
      m_in_frame = 1'b0;
      e_bv = 1'b0; e_err = 1'b0; e_found = 1'b0;
      e_x0 = 0; e_y0 = 0; e_x1 = 0; e_y1 = 0; e_cnt = 0;
      ov_on = 1'b0;
      repeat (2) @(posedge clk);
      #2;
      rst_n = 1'b1;
   endtask

   task automatic pin_detect(input string tag);
      chk({tag, "_found"}, g_found, 1);
      chk({tag, "_x0"}, g_x0, 2);
      chk({tag, "_y0"}, g_y0, 1);
      chk({tag, "_x1"}, g_x1, 5);
      chk({tag, "_y1"}, g_y1, 3);
      chk({tag, "_count"}, g_cnt, 3);
   endtask

   initial begin
      int r0, e0;
      #1;
      chk("init_valid_out", valid_out, 0);
      chk("init_bbox_valid", bbox_valid, 0);
      chk("init_bbox_count", bbox_count, 0);
      repeat (3) @(posedge clk);
      #2;
      rst_n = 1'b1;
      check_en = 1'b1;

      // pass-through, no matches
      rmode = 0;
      send_frame(32, 0, 1'b1, 0);
      drain();
      chk("pt_nres", nres, 1);
      chk("pt_found", g_found, 0);
      chk("pt_count", g_cnt, 0);

      // detection, then the same frame under alternating backpressure
      send_frame(32, 1, 1'b1, 0);
      drain();
      pin_detect("det");
      rmode = 1;
      send_frame(32, 1, 1'b1, 0);
      drain();
      pin_detect("bp");
      chk("bp_nres", nres, 3);

      // malformed: sop arrives as beat 10 of an open frame
      rmode = 0;
      e0 = nerr; r0 = nres;
      send_frame(10, 1, 1'b0, 0);
      send_frame(32, 1, 1'b1, 0);
      drain();
      chk("mal_err", nerr, e0 + 1);
      chk("mal_nres", nres, r0 + 1);
      pin_detect("mal");

      // reset mid-frame, then orphan beats that must not be accumulated
      send_frame(15, 1, 1'b0, 0);
      do_reset();
      r0 = nres;
      for (int i = 0; i < 5; i++) send_beat(1'b0, i == 4, 24'hC01010, 0);
      drain();
      chk("idle_nres", nres, r0);
      send_frame(32, 1, 1'b1, 0);
      drain();
      pin_detect("post_rst");

      // y saturation raises one frame_err
      e0 = nerr;
      send_frame(40, 3, 1'b1, 1);
      drain();
      chk("sat_err", nerr, e0 + 1);

      // single-pixel frame: below MIN_PIXELS but count reported
      send_beat(1'b1, 1'b1, 24'hC01010, 0);
      drain();
      chk("one_found", g_found, 0);
      chk("one_count", g_cnt, 1);

      // randomized frames with stalls, gaps, threshold churn and aborted frames
      for (int f = 0; f < 30; f++) begin
         int n;
         bit eop_f;
         rmode = $urandom_range(0, 2);
         n = $urandom_range(1, 40);
         eop_f = ($urandom_range(0, 5) != 0);
         for (int i = 0; i < n; i++) begin
            if ($urandom_range(0, 7) == 0) begin
               thr_min = {8'($urandom_range(8'h60, 8'hA0)), 8'($urandom_range(0, 16)), 8'($urandom_range(0, 16))};
               thr_max = {8'($urandom_range(8'hC0, 8'hFF)), 8'($urandom_range(8'h20, 8'h40)), 8'($urandom_range(8'h20, 8'h40))};
            end
            send_beat(i == 0, eop_f && (i == n-1), rand_pix(),
                      ($urandom_range(0, 2) == 0) ? $urandom_range(1, 3) : 0);
         end
         if ($urandom_range(0, 3) == 0)
            send_beat(1'b0, 1'($urandom_range(0, 1)), rand_pix(), 0);
      end
      rmode = 0;
      drain();

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not complete (got timeout, expected finish)");
      fails++;
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
